// File: rtl/aes_arb_pkg.sv
// Shared types and limits for the AES-128 request arbiter.
package aes_arb_pkg;

  localparam int unsigned N_REQ_MIN     = 2;
  localparam int unsigned N_REQ_MAX     = 8;
  localparam int unsigned TAG_DEPTH_MIN = 2;
  localparam int unsigned TAG_DEPTH_MAX = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Requester ID width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes_arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every block outstanding in the core.
module aes_arb_tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/aes_128_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between N_REQ requesters, with in-order result routing.
// Optional watchdog on the oldest outstanding block: define AES_ARB_TIMEOUT_EN.
module aes_128_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          kill,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [128*N_REQ-1:0]          req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          core_key_ready,
  output logic                          core_in_en,
  output logic [127:0]                  core_in_data,
  output logic                          core_kill,
  input  logic                          core_out_en,
  input  logic [127:0]                  core_out_data,
  output logic                          resp_valid,
  output logic [id_width(N_REQ)-1:0]    resp_id,
  output logic [127:0]                  resp_data,
  output logic                          busy,
  output logic                          err_orphan,
  output logic                          err_timeout
);

  localparam int unsigned IDW  = id_width(N_REQ);
  localparam int unsigned IDW1 = IDW + 1;
  localparam int unsigned DW   = 128;
  // Illegal configurations never grant, so a bad build is inert rather than corrupting.
  localparam bit CFG_OK = (N_REQ >= N_REQ_MIN) && (N_REQ <= N_REQ_MAX) &&
                          (TAG_DEPTH >= TAG_DEPTH_MIN) && (TAG_DEPTH <= TAG_DEPTH_MAX) &&
                          ((TAG_DEPTH & (TAG_DEPTH - 1)) == 0) && (TIMEOUT >= 2);

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW:0]   cand;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [DW-1:0]  win_data;
  logic           grant_en;
  logic           accept;
  logic           flush;
  logic           wd_kill;
  logic           pop;
  logic [IDW-1:0] fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;

  assign flush     = kill | wd_kill;
  assign core_kill = flush;
  assign grant_en  = CFG_OK && (state == IDLE) && core_key_ready && !fifo_full && !flush;
  assign accept    = grant_en && win_found;
  assign pop       = core_out_en && !fifo_empty;
  assign busy      = !fifo_empty;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + IDW1'(k);
      if (cand >= IDW1'(N_REQ)) cand = cand - IDW1'(N_REQ);
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_data     = req_data[DW*i +: DW];
        req_ready[i] = accept;
      end
    end
  end

  aes_arb_tag_fifo #(
    .W     (IDW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (accept),
    .pop   (pop),
    .din   (win_id),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM, round-robin pointer, core drive and result routing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      core_in_en   <= 1'b0;
      core_in_data <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_data    <= '0;
      err_orphan   <= 1'b0;
    end else begin
      state      <= accept ? ISSUE : IDLE;
      core_in_en <= accept;
      resp_valid <= pop && !flush;
      if (accept) begin
        core_in_data <= win_data;
        rr_ptr       <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
      end
      if (pop) begin
        resp_id   <= fifo_dout;
        resp_data <= core_out_data;
      end
      if (core_out_en && fifo_empty) err_orphan <= 1'b1;
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt;
  logic           wd_kill_q;
  logic           err_timeout_q;

  // Watchdog: age of the oldest outstanding block; fires once, then flushes like kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      wd_kill_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wd_kill_q <= 1'b0;
      if (flush || pop || (accept && fifo_empty)) begin
        wd_cnt <= '0;
      end else if (!fifo_empty) begin
        wd_cnt <= wd_cnt + WDW'(1);
        if (wd_cnt == WDW'(TIMEOUT - 1)) begin
          wd_kill_q     <= 1'b1;
          err_timeout_q <= 1'b1;
        end
      end
    end
  end

  assign wd_kill     = wd_kill_q;
  assign err_timeout = err_timeout_q;
`else
  assign wd_kill     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
